// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset sequencer.
// The state type and constants are used by the controller and the condition unit.
package mc_pkg;

  typedef logic [3:0] mc_state_t;

  localparam mc_state_t S_FETCH  = 4'd0;
  localparam mc_state_t S_DECODE = 4'd1;
  localparam mc_state_t S_MEMADR = 4'd2;
  localparam mc_state_t S_MEMRD  = 4'd3;
  localparam mc_state_t S_MEMWB  = 4'd4;
  localparam mc_state_t S_MEMWR  = 4'd5;
  localparam mc_state_t S_EXECR  = 4'd6;
  localparam mc_state_t S_EXECI  = 4'd7;
  localparam mc_state_t S_ALUWB  = 4'd8;
  localparam mc_state_t S_BRANCH = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] MUL_PATTERN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCA_RN    = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_if.sv
// Bundle between the sequencer (master) and the datapath / instruction register (slave).
interface mc_if;

  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        MemReq;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        AdrSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;
  logic        Illegal;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags, Illegal
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  MemReq, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags, Illegal
  );

endinterface

// File: rtl/mc_cond_unit.sv
// Condition-flag register with separate NZ / CV write enables, plus the
// combinational evaluator of the 4-bit condition field against the stored flags.
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_aluFlags,
  input  logic [1:0] i_flagW,
  input  logic [3:0] i_cond,
  output logic [3:0] o_flags,
  output logic       o_condOk
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_ge;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_ge    = (w_n == w_v);
  assign o_flags = r_flags;

  // i_flagW[1] writes N,Z; i_flagW[0] writes C,V
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_flagW[1]) r_flags[3:2] <= i_aluFlags[3:2];
      if (i_flagW[0]) r_flags[1:0] <= i_aluFlags[1:0];
    end
  end

  always_comb begin
    o_condOk = 1'b0;
    case (i_cond)
      COND_EQ: o_condOk = w_z;
      COND_NE: o_condOk = ~w_z;
      COND_CS: o_condOk = w_c;
      COND_CC: o_condOk = ~w_c;
      COND_MI: o_condOk = w_n;
      COND_PL: o_condOk = ~w_n;
      COND_VS: o_condOk = w_v;
      COND_VC: o_condOk = ~w_v;
      COND_HI: o_condOk = w_c & ~w_z;
      COND_LS: o_condOk = ~w_c | w_z;
      COND_GE: o_condOk = w_ge;
      COND_LT: o_condOk = ~w_ge;
      COND_GT: o_condOk = ~w_z & w_ge;
      COND_LE: o_condOk = w_z | ~w_ge;
      COND_AL: o_condOk = 1'b1;
      default: o_condOk = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencer: steps the shared datapath through fetch/decode/execute/
// memory/writeback, decodes the ALU command and owns the condition flags.
module mc_controller
  import mc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  mc_if.master  bus
);

  mc_state_t  r_state;
  mc_state_t  w_nextState;
  logic       r_condOk;
  logic       w_condEval;
  logic [3:0] w_flags;
  logic [1:0] w_flagW;

  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_cmd;
  logic       w_rdIsPc;
  logic       w_isMul;

  logic [2:0] w_aluCtrl;
  logic       w_noWrite;
  logic       w_cmdLegal;
  logic       w_arith;

  logic       w_memReq, w_memWrite, w_irWrite, w_pcWrite, w_regWrite, w_illegal;
  logic       w_adrSrc;
  logic [1:0] w_aluSrcA, w_aluSrcB, w_resultSrc, w_immSrc, w_regSrc;
  logic [2:0] w_aluControl;

  assign w_op     = bus.Instr[27:26];
  assign w_funct  = bus.Instr[25:20];
  assign w_cmd    = w_funct[4:1];
  assign w_rdIsPc = (bus.Instr[15:12] == 4'b1111);
  assign w_isMul  = (bus.Instr[7:4] == MUL_PATTERN);

  cond_unit u_condUnit (
    .clk        (clk),
    .reset      (reset),
    .i_aluFlags (bus.ALUFlags),
    .i_flagW    (w_flagW),
    .i_cond     (bus.Instr[31:28]),
    .o_flags    (w_flags),
    .o_condOk   (w_condEval)
  );

  // cond_ok is captured once in DECODE so later flag writes cannot change the verdict
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_condOk <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_DECODE) r_condOk <= w_condEval;
    end
  end

  always_comb begin
    w_aluCtrl  = ALU_ADD;
    w_noWrite  = 1'b0;
    w_cmdLegal = 1'b1;
    w_arith    = 1'b0;
    case (w_cmd)
      CMD_ADD: begin w_aluCtrl = ALU_ADD; w_arith = 1'b1; end
      CMD_SUB: begin w_aluCtrl = ALU_SUB; w_arith = 1'b1; end
      CMD_AND: w_aluCtrl = w_isMul ? ALU_MUL : ALU_AND;
      CMD_ORR: w_aluCtrl = ALU_ORR;
      CMD_MOV: w_aluCtrl = ALU_MOV;
      CMD_CMP: begin w_aluCtrl = ALU_SUB; w_arith = 1'b1; w_noWrite = 1'b1; end
      default: w_cmdLegal = 1'b0;
    endcase
  end

  always_comb begin
    w_immSrc = 2'b00;
    case (w_op)
      OP_MEM:  w_immSrc = 2'b01;
      OP_BR:   w_immSrc = 2'b10;
      default: w_immSrc = 2'b00;
    endcase
    w_regSrc = {(w_op == OP_MEM) & ~w_funct[0], (w_op == OP_BR)};
  end

  // Mux selects default to their FETCH values so reset and idle look identical
  always_comb begin
    w_nextState  = r_state;
    w_memReq     = 1'b0;
    w_memWrite   = 1'b0;
    w_irWrite    = 1'b0;
    w_pcWrite    = 1'b0;
    w_regWrite   = 1'b0;
    w_illegal    = 1'b0;
    w_adrSrc     = 1'b0;
    w_aluSrcA    = SRCA_PC;
    w_aluSrcB    = SRCB_FOUR;
    w_resultSrc  = RES_ALU;
    w_aluControl = ALU_ADD;
    w_flagW      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memReq = 1'b1;
        if (bus.MemReady) begin
          w_irWrite   = 1'b1;
          w_pcWrite   = 1'b1;
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          OP_DP:   w_nextState = w_funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  w_nextState = S_MEMADR;
          OP_BR:   w_nextState = S_BRANCH;
          default: begin w_illegal = 1'b1; w_nextState = S_FETCH; end
        endcase
      end
      S_MEMADR: begin
        w_aluSrcA   = SRCA_RN;
        w_aluSrcB   = SRCB_IMM;
        w_nextState = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adrSrc = 1'b1;
        w_memReq = 1'b1;
        if (bus.MemReady) w_nextState = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultSrc = RES_RDATA;
        w_regWrite  = r_condOk;
        w_nextState = S_FETCH;
      end
      S_MEMWR: begin
        w_adrSrc   = 1'b1;
        w_memReq   = 1'b1;
        w_memWrite = r_condOk;
        if (bus.MemReady) w_nextState = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_aluSrcA    = SRCA_RN;
        w_aluSrcB    = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RM;
        w_aluControl = w_aluCtrl;
        if (!w_cmdLegal) begin
          w_illegal   = 1'b1;
          w_nextState = S_FETCH;
        end else begin
          w_flagW     = {w_funct[0] & r_condOk, w_funct[0] & r_condOk & w_arith};
          w_nextState = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_resultSrc = RES_ALUOUT;
        w_regWrite  = r_condOk & ~w_noWrite;
        w_pcWrite   = r_condOk & ~w_noWrite & w_rdIsPc;
        w_nextState = S_FETCH;
      end
      S_BRANCH: begin
        w_aluSrcA   = SRCA_RN;
        w_aluSrcB   = SRCB_IMM;
        w_resultSrc = RES_ALU;
        w_pcWrite   = r_condOk;
        w_nextState = S_FETCH;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  assign bus.MemReq     = reset & w_memReq;
  assign bus.MemWrite   = reset & w_memWrite;
  assign bus.IRWrite    = reset & w_irWrite;
  assign bus.PCWrite    = reset & w_pcWrite;
  assign bus.RegWrite   = reset & w_regWrite;
  assign bus.Illegal    = reset & w_illegal;
  assign bus.AdrSrc     = w_adrSrc;
  assign bus.ALUSrcA    = w_aluSrcA;
  assign bus.ALUSrcB    = w_aluSrcB;
  assign bus.ResultSrc  = w_resultSrc;
  assign bus.ImmSrc     = w_immSrc;
  assign bus.RegSrc     = w_regSrc;
  assign bus.ALUControl = w_aluControl;
  assign bus.Flags      = w_flags;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus randomized instructions, each
// checked against an instruction-level model of cycles, write counts and flags.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;

  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] modelFlags = 4'b0000;
  logic [3:0] legalCmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};

  logic [31:0] rInstr;
  logic [3:0]  rCond, rCmd;
  logic [1:0]  rOp;
  logic        rS;
  logic [11:0] rLow;
  int          rSel;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] funct, input logic [3:0] rd,
                                     input logic [11:0] low);
    return {cond, op, funct, 4'd1, rd, low};
  endfunction

  // ARM condition table: pairs of codes share a base test, bit 0 inverts it
  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    base = 1'b1;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) return 1'b0;
    return cond[0] ? !base : base;
  endfunction

  // Expected ALUControl for a data-processing command, -1 when unimplemented
  function automatic int aluCode(input logic [3:0] cmd, input logic [3:0] low);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b1010: return 1;
      4'b0000: return (low == 4'b1001) ? 4 : 2;
      4'b1100: return 3;
      4'b1101: return 5;
      default: return -1;
    endcase
  endfunction

  // Runs one instruction from its first FETCH cycle; call at a falling edge
  task automatic applyStimulus(input string name, input logic [31:0] instr,
                               input logic [3:0] aluFlags, input int fetchWait,
                               input int memWait);
    logic [1:0] op, expImm, expRegSrc, immSeen, regSrcSeen;
    logic [3:0] cmd, expFlags;
    logic [2:0] aluSeen;
    bit ok, sBit, fetched, loaded, done, isFetch;
    int expCycles, expReg, expPc, expMem, expIll, expAlu;
    int cycles, regW, pcW, memW, ill, fLeft, mLeft;

    op   = instr[27:26];
    cmd  = instr[24:21];
    sBit = instr[20];
    ok   = condHolds(instr[31:28], modelFlags);
    expFlags = modelFlags;
    expReg = 0; expPc = 1; expMem = 0; expIll = 0; expAlu = -1; expCycles = 0;
    expImm    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    expRegSrc = {op == 2'b01 && !sBit, op == 2'b10};
    case (op)
      2'b00: begin
        expAlu = aluCode(cmd, instr[7:4]);
        if (expAlu < 0) begin
          expCycles = 3 + fetchWait;
          expIll = 1;
        end else begin
          expCycles = 4 + fetchWait;
          if (ok && cmd != 4'b1010) begin
            expReg = 1;
            if (instr[15:12] == 4'hF) expPc = 2;
          end
          if (ok && sBit) begin
            expFlags[3:2] = aluFlags[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
              expFlags[1:0] = aluFlags[1:0];
          end
        end
      end
      2'b01: begin
        if (sBit) begin
          expCycles = 5 + fetchWait + memWait;
          expReg = ok ? 1 : 0;
        end else begin
          expCycles = 4 + fetchWait + memWait;
          expMem = ok ? memWait + 1 : 0;
        end
      end
      2'b10: begin
        expCycles = 3 + fetchWait;
        expPc = ok ? 2 : 1;
      end
      default: begin
        expCycles = 2 + fetchWait;
        expIll = 1;
      end
    endcase

    cycles = 0; regW = 0; pcW = 0; memW = 0; ill = 0;
    fLeft = fetchWait; mLeft = memWait;
    fetched = 0; loaded = 0; done = 0;
    aluSeen = '0; immSeen = '0; regSrcSeen = '0;
    bus.ALUFlags = aluFlags;

    while (!done && cycles < 40) begin
      #1;
      isFetch = bus.MemReq && !bus.AdrSrc;
      if (fetched && isFetch) begin
        done = 1;
      end else begin
        if (isFetch) begin
          bus.MemReady = (fLeft == 0);
          if (fLeft > 0) fLeft--;
        end else if (bus.MemReq) begin
          bus.MemReady = (mLeft == 0);
          if (mLeft > 0) mLeft--;
        end else begin
          bus.MemReady = 1'($urandom_range(0, 1));
        end
        #1;
        regW += int'(bus.RegWrite);
        pcW  += int'(bus.PCWrite);
        memW += int'(bus.MemWrite);
        ill  += int'(bus.Illegal);
        if (cycles == fetchWait + 1) begin
          immSeen    = bus.ImmSrc;
          regSrcSeen = bus.RegSrc;
        end
        if (cycles == fetchWait + 2) aluSeen = bus.ALUControl;
        if (bus.IRWrite === 1'b1) fetched = 1;
        cycles++;
        @(posedge clk);
        #1;
        if (fetched && !loaded) begin
          bus.Instr = instr;
          loaded = 1;
        end
        @(negedge clk);
      end
    end

    checkOutput({name, " completed"}, 32'(done), 32'd1);
    checkOutput({name, " cycles"}, 32'(cycles), 32'(expCycles));
    checkOutput({name, " RegWrite count"}, 32'(regW), 32'(expReg));
    checkOutput({name, " PCWrite count"}, 32'(pcW), 32'(expPc));
    checkOutput({name, " MemWrite count"}, 32'(memW), 32'(expMem));
    checkOutput({name, " Illegal count"}, 32'(ill), 32'(expIll));
    checkOutput({name, " Flags"}, 32'(bus.Flags), 32'(expFlags));
    if (op != 2'b11) begin
      checkOutput({name, " ImmSrc"}, 32'(immSeen), 32'(expImm));
      checkOutput({name, " RegSrc"}, 32'(regSrcSeen), 32'(expRegSrc));
    end
    if (expAlu >= 0) checkOutput({name, " ALUControl"}, 32'(aluSeen), 32'(expAlu));
    modelFlags = expFlags;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.Instr    = 32'h0;
    bus.ALUFlags = 4'b0000;
    bus.MemReady = 1'b1;
    #2;
    checkOutput("reset MemReq", 32'(bus.MemReq), 32'd0);
    checkOutput("reset IRWrite", 32'(bus.IRWrite), 32'd0);
    checkOutput("reset PCWrite", 32'(bus.PCWrite), 32'd0);
    checkOutput("reset Flags", 32'(bus.Flags), 32'd0);
    checkOutput("reset AdrSrc", 32'(bus.AdrSrc), 32'd0);
    checkOutput("reset ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
    checkOutput("reset ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
    checkOutput("reset ResultSrc", 32'(bus.ResultSrc), 32'd2);

    @(negedge clk);
    reset = 1'b1;
    $display("[TB] directed phase");
    applyStimulus("ADD R1", mk(4'hE, 2'b00, 6'b001000, 4'd1, 12'h003), 4'b1111, 0, 0);
    applyStimulus("SUBS eq", mk(4'hE, 2'b00, 6'b000101, 4'd0, 12'h002), 4'b0100, 0, 0);
    applyStimulus("BEQ", mk(4'h0, 2'b10, 6'b100000, 4'd0, 12'h010), 4'b0000, 0, 0);
    applyStimulus("BNE", mk(4'h1, 2'b10, 6'b100000, 4'd0, 12'h010), 4'b0000, 0, 0);
    applyStimulus("LDR wait2", mk(4'hE, 2'b01, 6'b011001, 4'd4, 12'h008), 4'b0000, 0, 2);
    applyStimulus("CMP R1R1", mk(4'hE, 2'b00, 6'b010101, 4'd0, 12'h001), 4'b0110, 0, 0);
    applyStimulus("MULS", mk(4'hE, 2'b00, 6'b000001, 4'd5, 12'h092), 4'b1001, 0, 0);
    applyStimulus("op11", mk(4'hE, 2'b11, 6'b000000, 4'd0, 12'h000), 4'b0000, 0, 0);
    applyStimulus("NV ADDS", mk(4'hF, 2'b00, 6'b001001, 4'd15, 12'h003), 4'b1111, 0, 0);
    applyStimulus("ADD PC", mk(4'hE, 2'b00, 6'b001000, 4'd15, 12'h003), 4'b0000, 1, 0);
    applyStimulus("STR wait1", mk(4'hE, 2'b01, 6'b011000, 4'd6, 12'h004), 4'b0000, 2, 1);

    $display("[TB] random phase");
    for (int i = 0; i < 30; i++) begin
      rSel  = $urandom_range(0, 9);
      rCond = 4'($urandom);
      rOp   = (rSel < 5) ? 2'b00 : (rSel < 7) ? 2'b01 : (rSel < 9) ? 2'b10 : 2'b11;
      rCmd  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legalCmds[$urandom_range(0, 5)];
      rS    = 1'($urandom);
      if (aluCode(rCmd, 4'b0000) < 0) rS = 1'b0;
      rLow  = 12'($urandom);
      if ($urandom_range(0, 2) == 0) rLow[7:4] = 4'b1001;
      rInstr = mk(rCond, rOp, {1'($urandom), rCmd, rS}, 4'($urandom), rLow);
      applyStimulus($sformatf("rand%0d", i), rInstr, 4'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] reset during store");
    applyStimulus("ADDS ones", mk(4'hE, 2'b00, 6'b001001, 4'd2, 12'h005), 4'b1111, 0, 0);
    #1;
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    bus.Instr    = mk(4'hE, 2'b01, 6'b011000, 4'd3, 12'h010);
    bus.MemReady = 1'b0;
    for (int k = 0; k < 6 && !(bus.MemReq && bus.AdrSrc); k++) @(negedge clk);
    #1;
    checkOutput("pre-reset MemWrite", 32'(bus.MemWrite), 32'd1);
    checkOutput("pre-reset Flags", 32'(bus.Flags), 32'(modelFlags));
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort MemWrite", 32'(bus.MemWrite), 32'd0);
    checkOutput("abort MemReq", 32'(bus.MemReq), 32'd0);
    checkOutput("abort RegWrite", 32'(bus.RegWrite), 32'd0);
    checkOutput("abort AdrSrc", 32'(bus.AdrSrc), 32'd0);
    checkOutput("abort ALUSrcB", 32'(bus.ALUSrcB), 32'd2);
    checkOutput("abort Flags", 32'(bus.Flags), 32'd0);
    modelFlags = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("release MemReq", 32'(bus.MemReq), 32'd1);
    checkOutput("release AdrSrc", 32'(bus.AdrSrc), 32'd0);
    applyStimulus("post-reset ADD", mk(4'hE, 2'b00, 6'b001000, 4'd7, 12'h001), 4'b0000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
